// File: rtl/mailbox_avmm_initiator_pkg.sv
// Shared types and constants for the mailbox AVMM initiator.
// FIFO addresses match the platform mailbox register map.
package mailbox_avmm_initiator_pkg;

    localparam logic [7:0] WRITE_FIFO_ADDR = 8'h0B;
    localparam logic [7:0] READ_FIFO_ADDR  = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FETCH,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       write;
        logic       incr;
        logic [7:0] address;
    } cmd_hdr_t;

    function automatic cmd_hdr_t fifo_cmd(input logic write);
        cmd_hdr_t c;
        c.write   = write;
        c.incr    = 1'b0;
        c.address = write ? WRITE_FIFO_ADDR : READ_FIFO_ADDR;
        return c;
    endfunction

endpackage

// File: rtl/mailbox_avmm_initiator_stall_timer.sv
// Stall counter: counts enabled cycles, flags expiry at LIMIT.
// LIMIT of 0 never expires.
module mailbox_stall_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (LIMIT != 0) && en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mailbox_avmm_initiator.sv
// Byte-wide AVMM initiator for the SMBus mailbox register port.
// Runs incrementing bursts or fixed-address FIFO streams.
module mailbox_avmm_initiator
    import mailbox_avmm_initiator_pkg::*;
#(
    parameter int LEN_W         = 8,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_incr,
    input  logic [7:0]       cmd_address,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done,
    output logic             err_invalid,
    output logic             err_timeout,
    output logic [LEN_W-1:0] bytes_done,
    output logic             avm_read,
    output logic             avm_write,
    output logic [7:0]       avm_address,
    output logic [7:0]       avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_readdatavalid,
    input  logic             avm_waitrequest,
    input  logic             avm_invalid_cmd
);

    state_e           state_q, state_d;
    cmd_hdr_t         hdr_q, hdr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bytes_q, bytes_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             einv_q, einv_d;
    logic             eto_q, eto_d;

    logic [LEN_W-1:0] bytes_inc;
    logic [7:0]       addr_next;
    logic             stall_en;
    logic             stall_expired;
    logic [23:0]      unused_rdata;

    assign unused_rdata = avm_readdata[31:8];
    assign bytes_inc    = bytes_q + LEN_W'(1);
    assign addr_next    = hdr_q.address + {7'b0, hdr_q.incr};

    assign cmd_ready     = (state_q == ST_IDLE);
    assign wr_ready      = (state_q == ST_WR_FETCH) && wr_valid;
    assign avm_write     = (state_q == ST_WR_ISSUE);
    assign avm_read      = (state_q == ST_RD_ISSUE);
    assign avm_address   = hdr_q.address;
    assign avm_writedata = wdata_q;
    assign rd_data       = rdata_q;
    assign rd_valid      = rvalid_q;
    assign done          = (state_q == ST_DONE);
    assign err_invalid   = einv_q;
    assign err_timeout   = eto_q;
    assign bytes_done    = bytes_q;

    assign stall_en = (avm_read | avm_write) & avm_waitrequest;

    mailbox_stall_timer #(
        .LIMIT(STALL_TIMEOUT)
    ) u_stall (
        .clk    (clk),
        .reset  (reset),
        .en     (stall_en),
        .clr    (~stall_en),
        .expired(stall_expired)
    );

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        len_d    = len_q;
        bytes_d  = bytes_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        einv_d   = einv_q;
        eto_d    = eto_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    hdr_d.write   = cmd_write;
                    hdr_d.incr    = cmd_incr;
                    hdr_d.address = cmd_address;
                    len_d         = cmd_len;
                    bytes_d       = '0;
                    einv_d        = 1'b0;
                    eto_d         = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_write) begin
                        state_d = ST_WR_FETCH;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WR_FETCH: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                if (stall_expired) begin
                    eto_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!avm_waitrequest) begin
                    if (avm_invalid_cmd) begin
                        einv_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        bytes_d       = bytes_inc;
                        hdr_d.address = addr_next;
                        state_d = (bytes_inc == len_q) ? ST_DONE : ST_WR_FETCH;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (stall_expired) begin
                    eto_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!avm_waitrequest) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rdata_d  = avm_readdata[7:0];
                    rvalid_d = 1'b1;
                    bytes_d  = bytes_inc;
                    state_d  = ST_RD_HOLD;
                end
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    rvalid_d = 1'b0;
                    if (bytes_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        hdr_d.address = addr_next;
                        state_d       = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hdr_q    <= '0;
            len_q    <= '0;
            bytes_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            einv_q   <= 1'b0;
            eto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            len_q    <= len_d;
            bytes_q  <= bytes_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            einv_q   <= einv_d;
            eto_q    <= eto_d;
        end
    end

endmodule

// File: tb/tb_mailbox_avmm_initiator.sv
// Bench for mailbox_avmm_initiator: directed and random commands
// against a queue-based model of the mailbox port.
module tb_mailbox_avmm_initiator;
    import mailbox_avmm_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_incr;
    logic [7:0]  cmd_address, cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready;
    logic        done, err_invalid, err_timeout;
    logic [7:0]  bytes_done;
    logic        avm_read, avm_write;
    logic [7:0]  avm_address, avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid, avm_waitrequest, avm_invalid_cmd;

    always #5 clk = ~clk;

    mailbox_avmm_initiator #(.LEN_W(8), .STALL_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_incr(cmd_incr),
        .cmd_address(cmd_address), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err_invalid(err_invalid),
        .err_timeout(err_timeout), .bytes_done(bytes_done),
        .avm_read(avm_read), .avm_write(avm_write),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .avm_invalid_cmd(avm_invalid_cmd)
    );

    // Mailbox responder model
    bit          ws_rand = 1'b0;
    int          ws_max = 0;
    logic [7:0]  ws_fixed = 8'd0;
    bit          nack_en = 1'b0;
    bit          force_wait = 1'b0;
    bit          stray_rdv = 1'b0;
    logic [7:0]  ws_left = 8'd0;
    logic        rdv_q = 1'b0;
    logic [31:0] rdd_q = 32'd0;
    logic [7:0]  resp_q[$];
    int          resp_idx = 0;

    assign avm_waitrequest = force_wait ||
        ((avm_read || avm_write) && ws_left != 8'd0);
    assign avm_invalid_cmd = nack_en && (avm_read || avm_write) && !avm_waitrequest;
    assign avm_readdatavalid = rdv_q || stray_rdv;
    assign avm_readdata = rdd_q;

    always @(posedge clk) begin
        rdv_q <= 1'b0;
        rdd_q <= $urandom;
        if (!(avm_read || avm_write))
            ws_left <= ws_rand ? 8'($urandom_range(0, ws_max)) : ws_fixed;
        else if (avm_waitrequest && ws_left != 8'd0)
            ws_left <= ws_left - 8'd1;
        if (avm_read && !avm_waitrequest) begin
            rdv_q    <= 1'b1;
            rdd_q    <= {24'($urandom), resp_q[resp_idx]};
            resp_idx <= resp_idx + 1;
        end
    end

    int total = 0;
    int bad = 0;

    bit         wv_rand;
    int         rd_mode;
    bit         stray_en;
    logic [7:0] wq[$];
    logic [7:0] wa_log[$], wd_log[$], ra_log[$], rd_log[$];
    int consumed, stall_cyc, req_cyc, stab_viol, hold_viol, hold_total;
    int lat, lat_acc, hold_ctr, ncyc;
    logic [7:0] bd;
    logic ei, et;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic w, input logic inc,
                           input logic [7:0] a, input logic [7:0] len);
        bit pw, pr;
        logic [7:0] pa, pd;
        wa_log.delete(); wd_log.delete(); ra_log.delete(); rd_log.delete();
        consumed = 0; stall_cyc = 0; req_cyc = 0; stab_viol = 0;
        hold_viol = 0; hold_total = 0; lat = -1; lat_acc = -1; hold_ctr = 0;
        pw = 0; pr = 0; pa = 0; pd = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_incr = inc;
        cmd_address = a; cmd_len = len;
        #1 check("cmd_ready", 32'(cmd_ready), 1);
        ncyc = 0;
        while (ncyc < 300) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_len = 8'($urandom);
            wr_valid = (wq.size() > 0) && (!wv_rand || $urandom_range(0, 1) == 1);
            wr_data = (wq.size() > 0) ? wq[0] : 8'($urandom);
            stray_rdv = stray_en && ($urandom_range(0, 3) == 0);
            case (rd_mode)
                0: rd_ready = 1'b1;
                1: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = rd_valid && (hold_ctr >= 3);
            endcase
            #1;
            if (ncyc == 0) begin
                check("err_inv_clr", 32'(err_invalid), 0);
                check("err_to_clr", 32'(err_timeout), 0);
            end
            if (avm_write || avm_read) req_cyc++;
            if ((avm_write || avm_read) && avm_waitrequest) stall_cyc++;
            if ((pw || pr) && (avm_write || avm_read) &&
                {pw, pr, pa, pd} !== {avm_write, avm_read, avm_address, avm_writedata})
                stab_viol++;
            pw = avm_write && avm_waitrequest;
            pr = avm_read && avm_waitrequest;
            pa = avm_address; pd = avm_writedata;
            if (avm_write && !avm_waitrequest) begin
                wa_log.push_back(avm_address);
                wd_log.push_back(avm_writedata);
            end
            if (avm_read && !avm_waitrequest) begin
                ra_log.push_back(avm_address);
                if (lat_acc < 0) lat_acc = ncyc;
            end
            if (rd_valid && lat < 0 && lat_acc >= 0) lat = ncyc - lat_acc;
            if (rd_valid && !rd_ready) begin
                hold_total++;
                if (avm_read) hold_viol++;
                if (rd_mode == 2) hold_ctr++;
            end
            if (rd_valid && rd_ready) begin
                rd_log.push_back(rd_data);
                hold_ctr = 0;
            end
            if (wr_valid && wr_ready) begin
                consumed++;
                void'(wq.pop_front());
            end
            if (done) begin
                bd = bytes_done; ei = err_invalid; et = err_timeout;
                break;
            end
            ncyc++;
        end
        check("done_seen", 32'(ncyc < 300), 1);
        wr_valid = 1'b0; stray_rdv = 1'b0;
        @(negedge clk);
        #1;
        check("done_pulse_1cyc", 32'(done), 0);
        check("back_idle", 32'(cmd_ready), 1);
    endtask

    task automatic verify(input string tag, input logic w, input logic inc,
                          input logic [7:0] a, input logic [7:0] len,
                          input logic [7:0] exp_d[$]);
        check({tag, "_bytes"}, 32'(bd), 32'(len));
        check({tag, "_ei"}, 32'(ei), 0);
        check({tag, "_et"}, 32'(et), 0);
        check({tag, "_stab"}, stab_viol, 0);
        check({tag, "_holdrd"}, hold_viol, 0);
        if (w) begin
            check({tag, "_nwr"}, wa_log.size(), 32'(len));
            check({tag, "_nrd"}, ra_log.size() + rd_log.size(), 0);
            check({tag, "_used"}, consumed, 32'(len));
            for (int i = 0; i < wa_log.size() && i < len; i++) begin
                check({tag, "_wa"}, 32'(wa_log[i]), 32'(8'(a + (inc ? i : 0))));
                check({tag, "_wd"}, 32'(wd_log[i]), 32'(exp_d[i]));
            end
        end else begin
            check({tag, "_nacc"}, ra_log.size(), 32'(len));
            check({tag, "_nwr"}, wa_log.size(), 0);
            check({tag, "_nout"}, rd_log.size(), 32'(len));
            for (int i = 0; i < ra_log.size() && i < len; i++)
                check({tag, "_ra"}, 32'(ra_log[i]), 32'(8'(a + (inc ? i : 0))));
            for (int i = 0; i < rd_log.size() && i < len; i++)
                check({tag, "_rd"}, 32'(rd_log[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        logic [7:0] exp[$];
        logic [7:0] a, len;
        logic w, inc;
        int seen;
        reset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_incr = 0;
        cmd_address = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        wv_rand = 0; rd_mode = 0; stray_en = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_outs", {avm_read, avm_write, rd_valid, done,
                           err_invalid, err_timeout, wr_ready}, 0);
        check("rst_vals", {avm_address, avm_writedata, rd_data, bytes_done}, 0);

        exp = '{8'hA1, 8'hA2, 8'hA3};
        wq = exp;
        run_cmd(1'b1, 1'b1, 8'h10, 8'd3);
        verify("wr_incr", 1'b1, 1'b1, 8'h10, 8'd3, exp);

        exp = '{8'd5, 8'd6, 8'd7, 8'd8};
        foreach (exp[i]) resp_q.push_back(exp[i]);
        rd_mode = 2; nack_en = 1'b1;
        run_cmd(1'b0, 1'b0, fifo_cmd(1'b0).address, 8'd4);
        verify("rd_fifo", 1'b0, 1'b0, READ_FIFO_ADDR, 8'd4, exp);
        check("rd_lat", lat, 2);
        check("rd_held", hold_total, 12);
        rd_mode = 0; nack_en = 1'b0;

        ws_fixed = 8'd5;
        exp = '{8'h5A};
        wq = exp;
        run_cmd(1'b1, 1'b1, 8'h40, 8'd1);
        verify("wr_stall", 1'b1, 1'b1, 8'h40, 8'd1, exp);
        check("stall_cycles", stall_cyc, 5);
        ws_fixed = 8'd0;

        nack_en = 1'b1;
        wq = '{8'hB1, 8'hB2};
        run_cmd(1'b1, 1'b1, 8'h50, 8'd2);
        check("nack_ei", 32'(ei), 1);
        check("nack_bytes", 32'(bd), 0);
        check("nack_used", consumed, 1);
        check("nack_nwr", wa_log.size(), 1);
        check("nack_et", 32'(et), 0);
        check("nack_sticky", 32'(err_invalid), 1);
        nack_en = 1'b0;
        wq.delete();

        force_wait = 1'b1;
        wq = '{8'h77};
        run_cmd(1'b1, 1'b1, 8'h20, 8'd1);
        check("to_req_cycles", req_cyc, 8);
        check("to_et", 32'(et), 1);
        check("to_bytes", 32'(bd), 0);
        check("to_nwr", wa_log.size(), 0);
        force_wait = 1'b0;
        run_cmd(1'b0, 1'b1, 8'h30, 8'd0);
        check("len0_et", 32'(et), 0);
        check("len0_bus", req_cyc, 0);
        check("len0_bytes", 32'(bd), 0);

        exp = '{8'hC1, 8'hC2};
        wq = exp;
        run_cmd(1'b1, 1'b1, 8'hFF, 8'd2);
        verify("wr_wrap", 1'b1, 1'b1, 8'hFF, 8'd2, exp);

        ws_rand = 1'b1; ws_max = 3; wv_rand = 1'b1; rd_mode = 1;
        for (int k = 0; k < 12; k++) begin
            w = 1'($urandom_range(0, 1));
            inc = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            if (k < 2) a = 8'hFE;
            len = 8'($urandom_range(0, 6));
            if (!inc && $urandom_range(0, 1) == 1) a = fifo_cmd(w).address;
            exp.delete();
            for (int i = 0; i < len; i++) exp.push_back(8'($urandom));
            if (w) wq = exp;
            else foreach (exp[i]) resp_q.push_back(exp[i]);
            nack_en = !w && ($urandom_range(0, 1) == 1);
            stray_en = w;
            run_cmd(w, inc, a, len);
            verify("rand", w, inc, a, len, exp);
        end
        ws_rand = 1'b0; wv_rand = 1'b0; nack_en = 1'b0; stray_en = 1'b0;

        for (int i = 0; i < 4; i++) resp_q.push_back(8'($urandom));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_incr = 1'b1;
        cmd_address = 8'h60; cmd_len = 8'd4; rd_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1 if (rd_valid) seen = 1;
        end
        check("mid_rd_valid", seen, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mrst_ready", 32'(cmd_ready), 1);
        check("mrst_rdv", 32'(rd_valid), 0);
        check("mrst_req", {avm_read, avm_write}, 0);
        check("mrst_done", 32'(done), 0);
        reset = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_done", 32'(done), 0);
        check("post_rst_ready", 32'(cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mailbox_avmm_initiator.md
Name: mailbox_avmm_initiator

Overview:
- Byte-wide AVMM-like master that drives one SMBus-mailbox register-file port (the pch_*/bmc_* style port), i.e. the initiator side of that interface.
- Executes queued multi-byte commands: increment-address register bursts, or fixed-address FIFO streaming to the write/read FIFO addresses.
- Honours waitrequest arbitration, readdatavalid one-cycle read latency, and invalid_cmd NACK.
- Used by the provisioning/test path to load and read the mailbox without Nios involvement.

Parameters:
- LEN_W, 8, width of burst length field; max burst = 2**LEN_W - 1 bytes.
- STALL_TIMEOUT, 1024, cycles waitrequest may stay high on one access before abort; 0 disables the timeout.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_incr  in  1  1 = increment address per byte, 0 = fixed address (FIFO)
- cmd_address  in  8  start address
- cmd_len  in  LEN_W  byte count; 0 is legal
- wr_data  in  8  write byte stream
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  read byte presented, held until rd_ready
- rd_ready  in  1  sink accepts read byte
- done  out  1  one-cycle pulse at command end
- err_invalid  out  1  sticky, set by invalid_cmd; cleared on next cmd accept
- err_timeout  out  1  sticky, set by stall timeout; cleared on next cmd accept
- bytes_done  out  LEN_W  bytes completed in current/last command
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_address  out  8  access address
- avm_writedata  out  8  write byte
- avm_readdata  in  32  read data; only [7:0] used
- avm_readdatavalid  in  1  read data valid, one cycle after acceptance
- avm_waitrequest  in  1  access not accepted this cycle
- avm_invalid_cmd  in  1  write rejected (NACK), same cycle as acceptance

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1; state IDLE; FIFO not used.
- Acceptance: an access is accepted in the cycle avm_read|avm_write is high and avm_waitrequest is low. While waitrequest is high, avm_read, avm_write, avm_address and avm_writedata hold stable.
- At most one outstanding access.

States:
- IDLE: on cmd_valid, latch command, zero bytes_done, clear both error flags.
  - cmd_len == 0: go to DONE with no bus activity.
  - cmd_write = 1: go to WR_FETCH.
  - cmd_write = 0: go to RD_ISSUE.
- WR_FETCH: when wr_valid, pulse wr_ready, capture byte into avm_writedata, go to WR_ISSUE. No bus request is asserted until the byte is held.
- WR_ISSUE: avm_write = 1 until accepted. On acceptance:
  - avm_invalid_cmd = 1: set err_invalid, go to DONE (abort; remaining wr bytes not consumed).
  - otherwise: bytes_done++, address += cmd_incr; go to DONE if last byte, else WR_FETCH.
- RD_ISSUE: entered only with output register empty. avm_read = 1 until accepted, then RD_WAIT.
- RD_WAIT: on avm_readdatavalid, load avm_readdata[7:0] into rd_data, set rd_valid, bytes_done++, go to RD_HOLD.
- RD_HOLD: when rd_valid & rd_ready, clear rd_valid. Go to DONE if last byte, else RD_ISSUE with address += cmd_incr.
- DONE: done = 1 for one cycle, return to IDLE.

Timeout and address rules:
- Stall counter counts cycles with a pending request and waitrequest high; it resets on each acceptance.
- Reaching STALL_TIMEOUT deasserts the request, sets err_timeout and goes to DONE.
- Address arithmetic is 8-bit modulo: 0xFF + 1 = 0x00.
- Read-data latency: request acceptance to rd_valid = 2 cycles.

Boundary cases:
- avm_invalid_cmd while a read is being accepted: ignored.
- avm_readdatavalid outside RD_WAIT: ignored.
- Reset mid-burst: next cycle is IDLE; requests drop and rd_valid clears, with no done pulse.

Decomposition:
- Shared package: state enum, WRITE_FIFO_ADDR and READ_FIFO_ADDR constants (already in platform_defs_pkg), and a helper returning the fixed-address FIFO command.
- One sub-module: mailbox_stall_timer, a loadable counter with enable/clear and expiry flag.

Test Plan:
- Incr write, len 3, addr 0x10, bytes A1 A2 A3, no waitrequest -> writes at 0x10/0x11/0x12, done, bytes_done = 3, no errors.
- Fixed read, len 4, addr READ_FIFO_ADDR, responder returns 5 6 7 8 -> four reads all at that address, rd_data 5,6,7,8 in order; holding rd_ready low 3 cycles delays the next read.
- Write with waitrequest high 5 cycles -> address/data stable for those 5 cycles, single acceptance, no duplicate write.
- Write len 2 where the first access gets avm_invalid_cmd -> err_invalid = 1, done, bytes_done = 0, second wr byte not consumed.
- STALL_TIMEOUT = 8, waitrequest held high -> request drops after 8 cycles, err_timeout = 1, done pulse; next command clears err_timeout.
- Incr write at 0xFF, len 2 -> addresses 0xFF then 0x00. Separately, reset asserted mid-read -> IDLE, cmd_ready = 1, rd_valid = 0.
